// File: rtl/neuron_acc_ctrl.sv
// Round-robin arbiter and settle/capture/fire sequencer that shares one external ripple adder across N_REQ synapse requesters.
// Optional build macro NEURON_ACC_SAT_EN: saturate the membrane at all-ones on adder carry-out.
module neuron_acc_ctrl #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] weight,
  input  logic [WIDTH-1:0]       thresh,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_cout,
  output logic [WIDTH-1:0]       vmem,
  output logic                   spike,
  output logic                   busy
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, FIRE} state_t;

  state_t                      state_q;
  logic [PW-1:0]               ptr_q, own_q, win_idx;
  logic                        win_vld;
  logic [3:0]                  cnt_q;
  logic [WIDTH-1:0]            vmem_q, wgt_q, vmem_d;
  logic [N_REQ-1:0]            grant_q, ack_q;
  logic                        spike_q, busy_q;
  logic [N_REQ-1:0][WIDTH-1:0] w_arr;

  assign w_arr = weight;

  // Search starts at the requester after the last one acked.
  always_comb begin
    int k;
    k       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr_q) + i) % N_REQ;
      if (!win_vld && req[k]) begin
        win_vld = 1'b1;
        win_idx = PW'(k);
      end
    end
  end

`ifdef NEURON_ACC_SAT_EN
  assign vmem_d = add_cout ? '1 : add_sum;
`else
  logic unused_cout;
  assign unused_cout = add_cout;
  assign vmem_d      = add_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      vmem_q  <= '0;
      wgt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      spike_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: if (win_vld) begin
          own_q   <= win_idx;
          wgt_q   <= w_arr[win_idx];
          grant_q <= N_REQ'(1) << win_idx;
          cnt_q   <= 4'(SETTLE_CYC);
          busy_q  <= 1'b1;
          state_q <= SETTLE;
        end
        SETTLE: if (cnt_q <= 4'd1) begin
          cnt_q   <= '0;
          state_q <= CAPTURE;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        CAPTURE: begin
          vmem_q  <= vmem_d;
          ack_q   <= grant_q;
          grant_q <= '0;
          ptr_q   <= (own_q == PW'(N_REQ - 1)) ? '0 : own_q + 1'b1;
          if (vmem_d >= thresh) begin
            spike_q <= 1'b1;
            state_q <= FIRE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        FIRE: begin
          spike_q <= 1'b0;
          vmem_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operands come only from registers, so the adder sees stable inputs for the whole settle window.
  assign add_a   = busy_q ? vmem_q : '0;
  assign add_b   = busy_q ? wgt_q  : '0;
  assign add_cin = 1'b0;
  assign grant   = grant_q;
  assign ack     = ack_q;
  assign vmem    = vmem_q;
  assign spike   = spike_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_neuron_acc_ctrl.sv
// Bench for neuron_acc_ctrl: vector table, hand-written arbitration/reset sequences and randomized transactions against a transaction-level model.
module tb_neuron_acc_ctrl;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SC = 2;
`ifdef NEURON_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] weight;
  logic [W-1:0]   thresh;
  logic [N-1:0]   grant, ack;
  logic [W-1:0]   add_a, add_b, add_sum, vmem;
  logic           add_cin, add_cout, spike, busy;

  neuron_acc_ctrl #(.N_REQ(N), .WIDTH(W), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .req(req), .weight(weight), .thresh(thresh),
    .grant(grant), .ack(ack), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .vmem(vmem), .spike(spike), .busy(busy)
  );

  // Behavioural stand-in for the shared adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; weight = '0; thresh = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One transaction: drive, check grant/operands through settle+capture, check ack/vmem/spike after.
  task automatic do_txn(input logic [3:0] rq, input logic [31:0] wv, input logic [7:0] th,
                        input int idx, input logic [7:0] vm_exp, input bit fire,
                        input logic [7:0] vm_old, input string tag);
    logic [3:0] oh;
    logic [7:0] wexp;
    oh   = 4'b0001 << idx;
    wexp = wv[idx*8 +: 8];
    @(negedge clk);
    req = rq; weight = wv; thresh = th;
    for (int k = 1; k <= SC + 1; k++) begin
      @(negedge clk);
      chk({tag, " grant"}, 32'(grant), 32'(oh));
      chk({tag, " ack_early"}, 32'(ack), 32'd0);
      chk({tag, " add_b"}, 32'(add_b), 32'(wexp));
      chk({tag, " add_a"}, 32'(add_a), 32'(vm_old));
      chk({tag, " busy"}, 32'(busy), 32'd1);
      req    = 4'($urandom_range(0, 15));
      weight = $urandom;
    end
    @(negedge clk);
    chk({tag, " ack"}, 32'(ack), 32'(oh));
    chk({tag, " grant_off"}, 32'(grant), 32'd0);
    chk({tag, " vmem"}, 32'(vmem), 32'(vm_exp));
    chk({tag, " spike"}, 32'(spike), 32'(fire));
    req = '0;
    if (fire) begin
      @(negedge clk);
      chk({tag, " spike_end"}, 32'(spike), 32'd0);
      chk({tag, " vmem_clr"}, 32'(vmem), 32'd0);
      chk({tag, " busy_end"}, 32'(busy), 32'd0);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] rq, input int ptr);
    for (int i = 0; i < N; i++)
      if (rq[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  typedef struct {
    logic [3:0]  rq;
    logic [31:0] wv;
    logic [7:0]  th;
    int          idx;
    logic [7:0]  vm;
    bit          fire;
  } vec_t;

  initial begin
    vec_t tbl[9];
    logic [7:0] vm_cur;
    int nack, last_c;

    tbl[0] = '{4'b0001, 32'h0000000A, 8'd200, 0, 8'd10,  1'b0};
    tbl[1] = '{4'b0001, 32'h000000B9, 8'd200, 0, 8'd195, 1'b0};
    tbl[2] = '{4'b0010, 32'h00000500, 8'd200, 1, 8'd200, 1'b1};
    tbl[3] = '{4'b1001, 32'h03000007, 8'd255, 3, 8'd3,   1'b0};
    tbl[4] = '{4'b1001, 32'h03000007, 8'd255, 0, 8'd10,  1'b0};
    tbl[5] = '{4'b0100, 32'h00F00000, 8'd255, 2, 8'd250, 1'b0};
    tbl[6] = '{4'b0100, 32'h000A0000, 8'd255, 2, SAT ? 8'd255 : 8'd4, SAT};
    tbl[7] = '{4'b0010, 32'h00000000, 8'd0,   1, SAT ? 8'd0 : 8'd4,   1'b1};
    tbl[8] = '{4'b1111, 32'h04030201, 8'd255, 2, 8'd3,   1'b0};

    do_reset();
    @(negedge clk);
    chk("rst vmem", 32'(vmem), 32'd0);
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst spike", 32'(spike), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst add_a", 32'(add_a), 32'd0);
    chk("rst add_b", 32'(add_b), 32'd0);
    chk("add_cin", 32'(add_cin), 32'd0);

    vm_cur = 8'd0;
    for (int r = 0; r < 9; r++) begin
      do_txn(tbl[r].rq, tbl[r].wv, tbl[r].th, tbl[r].idx, tbl[r].vm, tbl[r].fire,
             vm_cur, $sformatf("tbl%0d", r));
      vm_cur = tbl[r].fire ? 8'd0 : tbl[r].vm;
    end

    // All four requesting continuously: rotating service, back-to-back every SC+2 cycles.
    do_reset();
    @(negedge clk);
    req = 4'b1111; weight = 32'h04030201; thresh = 8'd255;
    nack = 0; last_c = 0;
    for (int c = 1; c <= 40 && nack < 5; c++) begin
      @(negedge clk);
      if (|ack) begin
        chk($sformatf("arb ack%0d", nack), 32'(ack), 32'(4'b0001 << (nack % 4)));
        chk($sformatf("arb lat%0d", nack), 32'(c - last_c), 32'(SC + 2));
        if (nack == 3) chk("arb vmem4", 32'(vmem), 32'd10);
        last_c = c;
        nack++;
      end
    end
    chk("arb count", 32'(nack), 32'd5);
    req = '0;
    @(negedge clk);

    // Reset in the second settle cycle abandons the transaction.
    @(negedge clk);
    req = 4'b1000; weight = 32'h09000000; thresh = 8'd255;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid busy", 32'(busy), 32'd1);
    rst = 1'b1; req = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid grant", 32'(grant), 32'd0);
    chk("rstmid vmem", 32'(vmem), 32'd0);
    chk("rstmid busy0", 32'(busy), 32'd0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if ((|ack) || spike) seen = 1'b1;
      end
      chk("rstmid no ack/spike", 32'(seen), 32'd0);
    end
    do_txn(4'b1111, 32'h04030201, 8'd255, 0, 8'd1, 1'b0, 8'd0, "rstmid ptr0");

    // Randomized transactions against a transaction-level model.
    do_reset();
    begin
      int ptr_m, idx, sum;
      logic [7:0] vm_m, vm_new, th;
      logic [3:0] rq;
      logic [31:0] wv;
      bit fire;
      ptr_m = 0; vm_m = 8'd0;
      for (int t = 0; t < 60; t++) begin
        rq  = 4'($urandom_range(1, 15));
        wv  = $urandom;
        th  = 8'($urandom_range(0, 255));
        idx = rr_pick(rq, ptr_m);
        sum = int'(vm_m) + int'(wv[idx*8 +: 8]);
        vm_new = (SAT && sum > 255) ? 8'hFF : 8'(sum);
        fire   = (vm_new >= th);
        do_txn(rq, wv, th, idx, vm_new, fire, vm_m, $sformatf("rnd%0d", t));
        vm_m  = fire ? 8'd0 : vm_new;
        ptr_m = (idx + 1) % N;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
